// File: rtl/afe_pkg.sv
// Shared AFE definitions used by both the TX and RX paths.
//   AFE_DW      : ADC/DAC sample width
//   FIFO_W      : packed FIFO word width
//   I_LSB/Q_LSB : field positions of I and Q inside a FIFO word
//   rx_state_e  : receive alignment FSM states
//   sext16      : sign-extend a w-bit value held in the low bits of a 16-bit word
package afe_pkg;

  localparam int unsigned AFE_DW = 12;
  localparam int unsigned FIFO_W = 32;
  localparam int unsigned I_LSB  = 0;
  localparam int unsigned Q_LSB  = 16;

  typedef enum logic {
    RX_HUNT   = 1'b0,
    RX_LOCKED = 1'b1
  } rx_state_e;

  function automatic logic [15:0] sext16(input logic [15:0] x, input int unsigned w);
    logic [15:0] r;
    r = x;
    for (int unsigned b = 0; b < 16; b++) begin
      if (b >= w) r[b] = x[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/afe_rx.sv
// AFE receive path: registers interleaved I/Q ADC samples, aligns to the I/Q
// phase, and writes each well-formed pair as one packed word to the RX FIFO.
// Ports:
//   rx_sclk_2x   : sample clock (2x complex rate), all logic on rising edge
//   reset_n      : synchronous active-low reset
//   rx_en        : receive enable; low forces HUNT and suppresses writes
//   rx_d/rx_sel  : ADC data and phase (1 = I, 0 = Q)
//   rx_fifo_full : FIFO full, checked in the write-decision cycle
//   rx_fifo_clk  : FIFO write clock (same as rx_sclk_2x)
//   rx_fifo_wr   : one-cycle write strobe
//   rx_fifo_data : [15:0] = I, [31:16] = Q, both sign-extended
//   rx_locked    : high while phase-locked
//   rx_sync_err  : one-cycle pulse on a phase error while locked
//   rx_ovf_cnt   : saturating count of pairs dropped because the FIFO was full
module afe_rx
  import afe_pkg::*;
#(
  parameter int unsigned DW       = AFE_DW,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned OVF_W    = 16
) (
  input  logic              rx_sclk_2x,
  input  logic              reset_n,
  input  logic              rx_en,
  input  logic [DW-1:0]     rx_d,
  input  logic              rx_sel,
  input  logic              rx_fifo_full,
  output logic              rx_fifo_clk,
  output logic              rx_fifo_wr,
  output logic [FIFO_W-1:0] rx_fifo_data,
  output logic              rx_locked,
  output logic              rx_sync_err,
  output logic [OVF_W-1:0]  rx_ovf_cnt
);

  localparam int unsigned LCW = $clog2(LOCK_CNT + 1);

  generate
    if (DW > 16) begin : g_dw_illegal
      $error("afe_rx: DW must not exceed 16");
    end
  endgenerate

  rx_state_e         state_q, state_d;
  logic [DW-1:0]     d_q, d_d;
  logic              sel_q, sel_d;
  logic              in_vld_q, in_vld_d;
  logic              prev_sel_q, prev_sel_d;
  logic              prev_vld_q, prev_vld_d;
  logic [DW-1:0]     i_q, i_d;
  logic [LCW-1:0]    lock_cnt_q, lock_cnt_d;
  logic              wr_q, wr_d;
  logic [FIFO_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [OVF_W-1:0]  ovf_q, ovf_d;

  logic phase_err;
  logic pair_done;

  // prev_vld_q qualifies the previous registered sample; clearing it is how a
  // partial I is discarded (reset, rx_en low).
  assign phase_err = in_vld_q && prev_vld_q && (prev_sel_q == sel_q);
  assign pair_done = in_vld_q && prev_vld_q && prev_sel_q && !sel_q;

  always_comb begin
    state_d    = state_q;
    d_d        = rx_d;
    sel_d      = rx_sel;
    in_vld_d   = 1'b1;
    prev_sel_d = prev_sel_q;
    prev_vld_d = prev_vld_q;
    i_d        = i_q;
    lock_cnt_d = lock_cnt_q;
    wr_d       = 1'b0;
    data_d     = data_q;
    err_d      = 1'b0;
    ovf_d      = ovf_q;

    if (!rx_en) begin
      state_d    = RX_HUNT;
      lock_cnt_d = '0;
      prev_vld_d = 1'b0;
    end else if (in_vld_q) begin
      prev_sel_d = sel_q;
      prev_vld_d = 1'b1;
      if (sel_q) i_d = d_q;

      unique case (state_q)
        RX_HUNT: begin
          if (phase_err) begin
            lock_cnt_d = '0;
          end else if (pair_done) begin
            if (lock_cnt_q == LCW'(LOCK_CNT - 1)) begin
              state_d    = RX_LOCKED;
              lock_cnt_d = '0;
            end else begin
              lock_cnt_d = lock_cnt_q + 1'b1;
            end
          end
        end
        RX_LOCKED: begin
          if (phase_err) begin
            state_d    = RX_HUNT;
            lock_cnt_d = '0;
            err_d      = 1'b1;
          end else if (pair_done) begin
            if (rx_fifo_full) begin
              if (ovf_q != '1) ovf_d = ovf_q + 1'b1;
            end else begin
              wr_d                 = 1'b1;
              data_d[I_LSB +: 16]  = sext16(16'(i_q), DW);
              data_d[Q_LSB +: 16]  = sext16(16'(d_q), DW);
            end
          end
        end
        default: state_d = RX_HUNT;
      endcase
    end
  end

  always_ff @(posedge rx_sclk_2x) begin
    if (!reset_n) begin
      state_q    <= RX_HUNT;
      d_q        <= '0;
      sel_q      <= 1'b0;
      in_vld_q   <= 1'b0;
      prev_sel_q <= 1'b0;
      prev_vld_q <= 1'b0;
      i_q        <= '0;
      lock_cnt_q <= '0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      sel_q      <= sel_d;
      in_vld_q   <= in_vld_d;
      prev_sel_q <= prev_sel_d;
      prev_vld_q <= prev_vld_d;
      i_q        <= i_d;
      lock_cnt_q <= lock_cnt_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign rx_fifo_clk  = rx_sclk_2x;
  assign rx_fifo_wr   = wr_q;
  assign rx_fifo_data = data_q;
  assign rx_locked    = (state_q == RX_LOCKED);
  assign rx_sync_err  = err_q;
  assign rx_ovf_cnt   = ovf_q;

endmodule

// File: tb/tb_afe_rx.sv
module tb_afe_rx;

  localparam int LOCK_PAIRS = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_en;
  logic [11:0] rx_d;
  logic        rx_sel;
  logic        rx_fifo_full;

  logic        fifo_clk, wr, locked, sync_err;
  logic [31:0] data;
  logic [15:0] ovf;
  logic        d2_fifo_clk, d2_wr, d2_locked, d2_sync_err;
  logic [31:0] d2_data;
  logic [1:0]  d2_ovf;

  always #5 clk = ~clk;

  afe_rx dut (
    .rx_sclk_2x(clk), .reset_n(reset_n), .rx_en(rx_en), .rx_d(rx_d), .rx_sel(rx_sel),
    .rx_fifo_full(rx_fifo_full), .rx_fifo_clk(fifo_clk), .rx_fifo_wr(wr),
    .rx_fifo_data(data), .rx_locked(locked), .rx_sync_err(sync_err), .rx_ovf_cnt(ovf)
  );

  afe_rx #(.OVF_W(2)) dut_ovf2 (
    .rx_sclk_2x(clk), .reset_n(reset_n), .rx_en(rx_en), .rx_d(rx_d), .rx_sel(rx_sel),
    .rx_fifo_full(rx_fifo_full), .rx_fifo_clk(d2_fifo_clk), .rx_fifo_wr(d2_wr),
    .rx_fifo_data(d2_data), .rx_locked(d2_locked), .rx_sync_err(d2_sync_err),
    .rx_ovf_cnt(d2_ovf)
  );

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  // Reference model: a two-deep history of registered samples.
  bit          h_vld, p_vld, h_sel, p_sel;
  logic [11:0] h_d, p_d;
  int          m_pairs, m_ovf, m_ovf2;
  bit          m_locked, m_wr, m_err;
  logic [31:0] m_data;

  typedef struct {
    logic [11:0] i;
    logic [11:0] q;
    logic [31:0] word;
  } vec_t;
  vec_t vt [4];

  function automatic logic [15:0] sx(input logic [11:0] x);
    int v;
    v = int'(x);
    if (v >= 2048) v = v - 4096;
    return 16'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    m_wr  = 1'b0;
    m_err = 1'b0;
    if (!reset_n) begin
      h_vld = 0; p_vld = 0; m_pairs = 0; m_locked = 0;
      m_data = '0; m_ovf = 0; m_ovf2 = 0;
    end else begin
      if (!rx_en) begin
        m_locked = 0; m_pairs = 0; p_vld = 0;
      end else if (h_vld) begin
        if (p_vld && p_sel == h_sel) begin
          m_err = m_locked; m_locked = 0; m_pairs = 0;
        end else if (p_vld && p_sel && !h_sel) begin
          if (!m_locked) begin
            m_pairs++;
            m_locked = (m_pairs >= LOCK_PAIRS);
          end else if (rx_fifo_full) begin
            m_ovf  = (m_ovf  < 65535) ? m_ovf  + 1 : m_ovf;
            m_ovf2 = (m_ovf2 < 3)     ? m_ovf2 + 1 : m_ovf2;
          end else begin
            m_wr   = 1'b1;
            m_data = {sx(h_d), sx(p_d)};
          end
        end
        p_vld = 1; p_sel = h_sel; p_d = h_d;
      end
      h_vld = 1; h_sel = rx_sel; h_d = rx_d;
    end
  endtask

  task automatic compare();
    chk("fifo_clk", 32'(fifo_clk), 32'(clk));
    chk("wr",       32'(wr),       32'(m_wr));
    chk("data",     data,          m_data);
    chk("locked",   32'(locked),   32'(m_locked));
    chk("sync_err", 32'(sync_err), 32'(m_err));
    chk("ovf",      32'(ovf),      32'(m_ovf));
    chk("d2_clk",   32'(d2_fifo_clk), 32'(clk));
    chk("d2_wr",    32'(d2_wr),    32'(m_wr));
    chk("d2_data",  d2_data,       m_data);
    chk("d2_locked", 32'(d2_locked), 32'(m_locked));
    chk("d2_err",   32'(d2_sync_err), 32'(m_err));
    chk("d2_ovf",   32'(d2_ovf),   32'(m_ovf2));
    if (wr === 1'b1) wr_cnt++;
  endtask

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic step(input logic s, input logic [11:0] d);
    rx_sel = s;
    rx_d   = d;
    tick();
  endtask

  task automatic pair(input logic [11:0] i, input logic [11:0] q);
    step(1'b1, i);
    step(1'b0, q);
  endtask

  initial begin
    int   w0;
    logic s;

    vt[0] = '{12'h123, 12'hFED, 32'hFFED0123};
    vt[1] = '{12'h000, 12'hFFF, 32'hFFFF0000};
    vt[2] = '{12'h7FF, 12'h001, 32'h000107FF};
    vt[3] = '{12'hABC, 12'h555, 32'h0555FABC};

    reset_n = 1'b0; rx_en = 1'b1; rx_sel = 1'b0; rx_d = '0; rx_fifo_full = 1'b0;
    @(negedge clk);
    tick(); tick();
    chk("rst_wr", 32'(wr), 0);
    chk("rst_data", data, 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_ovf", 32'(ovf), 0);

    // 1: lock after four pairs, fifth pair written two cycles after its Q
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) pair(12'h123, 12'hFED);
    chk("t1_not_locked_yet", 32'(locked), 0);
    step(1'b1, 12'h123);
    chk("t1_locked", 32'(locked), 1);
    chk("t1_lock_pair_unwritten", wr_cnt, 0);
    step(1'b0, 12'hFED);
    chk("t1_wr_not_early", 32'(wr), 0);
    step(1'b1, 12'h123);
    chk("t1_wr", 32'(wr), 1);
    chk("t1_data", data, 32'hFFED0123);
    step(1'b0, 12'hFED);
    chk("t1_wr_single", 32'(wr), 0);

    // 2: I,I phase error while locked, then relock
    step(1'b1, 12'h111);
    step(1'b1, 12'h222);
    chk("t2_err_before", 32'(sync_err), 0);
    step(1'b0, 12'h333);
    chk("t2_err_pulse", 32'(sync_err), 1);
    chk("t2_unlocked", 32'(locked), 0);
    chk("t2_no_wr", 32'(wr), 0);
    step(1'b1, 12'h444);
    chk("t2_err_one_cycle", 32'(sync_err), 0);
    chk("t2_no_wr2", 32'(wr), 0);
    step(1'b0, 12'h555);
    pair(12'h666, 12'h777);
    pair(12'h888, 12'h999);
    chk("t2_not_relocked_yet", 32'(locked), 0);
    step(1'b1, 12'h0AA);
    chk("t2_relocked", 32'(locked), 1);
    step(1'b0, 12'h0BB);

    // sign-extension / packing table
    foreach (vt[k]) begin
      step(1'b1, vt[k].i);
      step(1'b0, vt[k].q);
      step(1'b1, 12'h000);
      chk("tbl_wr", 32'(wr), 1);
      chk("tbl_data", data, vt[k].word);
      step(1'b0, 12'h000);
    end

    // 3: FIFO full for three pairs
    step(1'b1, 12'h0A1);
    w0 = wr_cnt;
    rx_fifo_full = 1'b1;
    step(1'b0, 12'h0B1);
    pair(12'h0A2, 12'h0B2);
    pair(12'h0A3, 12'h0B3);
    step(1'b1, 12'h0A4);
    rx_fifo_full = 1'b0;
    step(1'b0, 12'h0B4);
    step(1'b1, 12'h0A5);
    chk("t3_ovf", 32'(ovf), 3);
    chk("t3_wr_after_full", 32'(wr), 1);
    chk("t3_data", data, 32'h00B400A4);
    chk("t3_one_write", wr_cnt - w0, 1);
    chk("t3_locked", 32'(locked), 1);
    step(1'b0, 12'h0B5);

    // 5: extreme values, then rx_en dropped mid-pair
    pair(12'h800, 12'h7FF);
    step(1'b1, 12'h000);
    chk("t5_data", data, 32'h07FFF800);
    step(1'b0, 12'h000);
    step(1'b1, 12'h321);
    w0 = wr_cnt;
    rx_en = 1'b0;
    step(1'b0, 12'h654);
    chk("t5_unlocked", 32'(locked), 0);
    step(1'b1, 12'h000);
    step(1'b0, 12'h000);
    chk("t5_no_write", wr_cnt - w0, 0);
    chk("t5_ovf_held", 32'(ovf), 3);
    rx_en = 1'b1;

    // 6: reset mid-pair while locked
    for (int k = 0; k < 4; k++) pair(12'h050, 12'h060);
    step(1'b1, 12'h001);
    chk("t6_locked", 32'(locked), 1);
    reset_n = 1'b0;
    step(1'b0, 12'h002);
    chk("t6_rst_wr", 32'(wr), 0);
    chk("t6_rst_data", data, 0);
    chk("t6_rst_locked", 32'(locked), 0);
    chk("t6_rst_err", 32'(sync_err), 0);
    chk("t6_rst_ovf", 32'(ovf), 0);
    reset_n = 1'b1;
    w0 = wr_cnt;
    step(1'b0, 12'h003);
    for (int k = 0; k < 4; k++) pair(12'h010, 12'h020);
    chk("t6_not_locked_yet", 32'(locked), 0);
    step(1'b1, 12'h010);
    chk("t6_relocked", 32'(locked), 1);
    step(1'b0, 12'h020);
    step(1'b1, 12'h011);
    chk("t6_wr", 32'(wr), 1);
    chk("t6_data", data, 32'h00200010);
    chk("t6_first_write_only", wr_cnt - w0, 1);

    // 4: six full pairs; 2-bit counter saturates at 3
    step(1'b0, 12'h021);
    step(1'b1, 12'h031);
    rx_fifo_full = 1'b1;
    step(1'b0, 12'h041);
    for (int k = 0; k < 5; k++) pair(12'h100, 12'h200);
    step(1'b1, 12'h100);
    rx_fifo_full = 1'b0;
    chk("t4_ovf16", 32'(ovf), 6);
    chk("t4_ovf2_sat", 32'(d2_ovf), 3);
    step(1'b0, 12'h200);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset_n      = ($urandom_range(0, 299) != 0);
      rx_en        = ($urandom_range(0, 39) != 0);
      rx_fifo_full = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 15) == 0) s = 1'($urandom_range(0, 1));
      else s = ~rx_sel;
      step(s, 12'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
